// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to the transmitter), default bit
// period and frame width.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_state_e;

    // 25 MHz / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 217;
    localparam int DATA_BITS            = 8;

    // Offset from the start edge to the middle of the start bit.
    function automatic int half_bit(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both stages reset to RESET_VAL.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronizes RX, validates the start bit at mid-bit, samples eight
// data bits LSB-first and checks the stop bit, strobing either a good byte or a framing error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_Frame_Err
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BIDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(half_bit(CLKS_PER_BIT));
    localparam logic [BIDX_W-1:0] BIT_LAST = BIDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BIDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]     shift_q, shift_d;
    logic [DATA_BITS-1:0]     byte_q, byte_d;
    logic                     dv_q, dv_d;
    logic                     fe_q, fe_d;
    logic                     active_q, active_d;

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk(CLK),
        .rst(RST),
        .d  (RX),
        .q  (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
        active_d  = active_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end

            // A start bit that is no longer low at mid-bit is treated as line noise.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                    end else begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        fe_d   = 1'b1;
                    end
                    active_d = 1'b0;
                    state_d  = CLEANUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Waiting for the line to return high keeps a held-low break from re-triggering.
            CLEANUP: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
            active_q  <= active_d;
        end
    end

    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
    end

    assign o_RX_DV     = dv_q;
    assign o_RX_Byte   = byte_q;
    assign o_RX_Active = active_q;
    assign o_Frame_Err = fe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three receivers (8, 7 and 9 clocks per bit) driven by directed frames,
// checked every cycle against a timeline model plus literal expectations.
module tb_uart_rx;

    localparam int N     = 3;
    localparam int DEPTH = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx_line;
    logic [2:0] dv, fe, act;
    logic [7:0] byte_o [N];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(8)) dut0 (
        .CLK(clk), .RST(rst), .RX(rx_line[0]),
        .o_RX_DV(dv[0]), .o_RX_Byte(byte_o[0]), .o_RX_Active(act[0]), .o_Frame_Err(fe[0])
    );
    uart_rx #(.CLKS_PER_BIT(7)) dut1 (
        .CLK(clk), .RST(rst), .RX(rx_line[1]),
        .o_RX_DV(dv[1]), .o_RX_Byte(byte_o[1]), .o_RX_Active(act[1]), .o_Frame_Err(fe[1])
    );
    uart_rx #(.CLKS_PER_BIT(9)) dut2 (
        .CLK(clk), .RST(rst), .RX(rx_line[2]),
        .o_RX_DV(dv[2]), .o_RX_Byte(byte_o[2]), .o_RX_Active(act[2]), .o_Frame_Err(fe[2])
    );

    // Expected outputs indexed by clock-edge number (value right after that edge).
    bit         exp_dv  [N][DEPTH];
    bit         exp_fe  [N][DEPTH];
    bit         exp_act [N][DEPTH];
    logic [7:0] exp_b   [N][DEPTH];
    bit         rst_evt [DEPTH];
    logic [7:0] model_byte [N];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int print_cnt = 0;
    int dv_cnt [N];
    int fe_cnt [N];
    int last_dv [N];
    int prev_dv [N];
    int act_rise [N];
    int act_fall [N];
    bit act_prev [N];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cpb_of(input int k);
        if (k == 0) return 8;
        if (k == 1) return 7;
        return 9;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            if (print_cnt < 60) begin
                print_cnt++;
                $display("FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, cyc);
            end
        end
    endtask

    task automatic clear_from(input int n);
        for (int k = 0; k < N; k++) begin
            for (int i = n; i < DEPTH; i++) begin
                exp_dv[k][i]  = 1'b0;
                exp_fe[k][i]  = 1'b0;
                exp_act[k][i] = 1'b0;
            end
        end
    endtask

    // Drives one frame on receiver k starting at the current negedge. abort_at >= 0 pulses
    // reset after that many bit-clock cycles and abandons the frame.
    task automatic send_frame(input int k, input logic [7:0] b, input logic stop_v,
                              input int stop_len, input int abort_at);
        int   c, h, e0, ee, total;
        logic v;
        c  = cpb_of(k);
        h  = (c - 1) / 2;
        e0 = cyc + 1;
        ee = e0 + 3 + h + 9 * c;
        for (int n = e0 + 2; n < ee && n < DEPTH; n++) exp_act[k][n] = 1'b1;
        if (ee < DEPTH) begin
            if (stop_v) begin
                exp_dv[k][ee] = 1'b1;
                exp_b[k][ee]  = b;
            end else begin
                exp_fe[k][ee] = 1'b1;
            end
        end
        total = 9 * c + stop_len;
        for (int t = 0; t < total; t++) begin
            if (t == abort_at) begin
                rst     = 1'b1;
                rx_line = 3'b111;
                clear_from(cyc + 1);
                rst_evt[cyc + 1] = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (t < c)          v = 1'b0;
            else if (t < 9 * c) v = b[(t - c) / c];
            else                v = stop_v;
            rx_line[k] = v;
            @(negedge clk);
        end
        rx_line[k] = 1'b1;
    endtask

    task automatic glitch(input int k, input int len);
        int c, h, e0;
        c  = cpb_of(k);
        h  = (c - 1) / 2;
        e0 = cyc + 1;
        for (int n = e0 + 2; n < e0 + 3 + h; n++) exp_act[k][n] = 1'b1;
        rx_line[k] = 1'b0;
        repeat (len) @(negedge clk);
        rx_line[k] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < DEPTH) begin
            if (rst_evt[cyc]) begin
                for (int k = 0; k < N; k++) model_byte[k] = 8'h00;
            end
            for (int k = 0; k < N; k++) begin
                if (exp_dv[k][cyc]) model_byte[k] = exp_b[k][cyc];
                check($sformatf("dut%0d_dv", k),     {31'b0, dv[k]},  {31'b0, exp_dv[k][cyc]});
                check($sformatf("dut%0d_ferr", k),   {31'b0, fe[k]},  {31'b0, exp_fe[k][cyc]});
                check($sformatf("dut%0d_active", k), {31'b0, act[k]}, {31'b0, exp_act[k][cyc]});
                check($sformatf("dut%0d_byte", k),   {24'b0, byte_o[k]}, {24'b0, model_byte[k]});
                if (dv[k] === 1'b1) begin
                    dv_cnt[k]++;
                    prev_dv[k] = last_dv[k];
                    last_dv[k] = cyc;
                end
                if (fe[k] === 1'b1) fe_cnt[k]++;
                if (act[k] === 1'b1 && !act_prev[k]) act_rise[k] = cyc;
                if (act[k] === 1'b0 && act_prev[k])  act_fall[k] = cyc;
                act_prev[k] = (act[k] === 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0_a, e0_b, e0_c, e0_d;
        for (int k = 0; k < N; k++) begin
            model_byte[k] = 8'h00;
            dv_cnt[k] = 0; fe_cnt[k] = 0; last_dv[k] = -1; prev_dv[k] = -1;
            act_rise[k] = -1; act_fall[k] = -1; act_prev[k] = 1'b0;
        end
        rst     = 1'b1;
        rx_line = 3'b111;
        repeat (4) @(negedge clk);
        check("reset_byte",   {24'b0, byte_o[0]}, 32'h00);
        check("reset_dv",     {31'b0, dv[0]},     32'h0);
        check("reset_active", {31'b0, act[0]},    32'h0);
        check("reset_ferr",   {31'b0, fe[0]},     32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single good frame
        e0_a = cyc + 1;
        send_frame(0, 8'hA5, 1'b1, 8, -1);
        repeat (8) @(negedge clk);
        check("t1_byte",        {24'b0, byte_o[0]}, 32'hA5);
        check("t1_dv_edge",     last_dv[0],  e0_a + 78);
        check("t1_dv_count",    dv_cnt[0],   1);
        check("t1_ferr_count",  fe_cnt[0],   0);
        check("t1_active_rise", act_rise[0], e0_a + 2);
        check("t1_active_fall", act_fall[0], e0_a + 78);

        // 2: back-to-back frames
        e0_b = cyc + 1;
        send_frame(0, 8'h00, 1'b1, 8, -1);
        check("t2_first_byte", {24'b0, byte_o[0]}, 32'h00);
        send_frame(0, 8'hFF, 1'b1, 8, -1);
        repeat (8) @(negedge clk);
        check("t2_second_byte", {24'b0, byte_o[0]}, 32'hFF);
        check("t2_dv_spacing",  last_dv[0] - prev_dv[0], 80);
        check("t2_first_edge",  prev_dv[0], e0_b + 78);
        check("t2_dv_count",    dv_cnt[0], 3);

        // 3: start-bit glitch
        glitch(0, 3);
        repeat (20) @(negedge clk);
        check("t3_byte_kept", {24'b0, byte_o[0]}, 32'hFF);
        check("t3_dv_count",  dv_cnt[0], 3);
        check("t3_ferr_count", fe_cnt[0], 0);

        // 4: framing error with a held-low line, then recovery
        e0_c = cyc + 1;
        send_frame(0, 8'h3C, 1'b0, 40, -1);
        repeat (16) @(negedge clk);
        check("t4_ferr_count", fe_cnt[0], 1);
        check("t4_byte_kept",  {24'b0, byte_o[0]}, 32'hFF);
        check("t4_dv_count",   dv_cnt[0], 3);
        send_frame(0, 8'h5A, 1'b1, 8, -1);
        repeat (8) @(negedge clk);
        check("t4_recover_byte", {24'b0, byte_o[0]}, 32'h5A);
        check("t4_recover_dv",   dv_cnt[0], 4);
        check("t4_ferr_once",    fe_cnt[0], 1);

        // 5: reset during data bit 4
        send_frame(0, 8'h81, 1'b1, 8, 43);
        repeat (16) @(negedge clk);
        check("t5_byte_cleared", {24'b0, byte_o[0]}, 32'h00);
        check("t5_no_strobe",    dv_cnt[0], 4);
        send_frame(0, 8'h42, 1'b1, 8, -1);
        repeat (8) @(negedge clk);
        check("t5_next_byte", {24'b0, byte_o[0]}, 32'h42);
        check("t5_dv_count",  dv_cnt[0], 5);

        // 6: other bit periods
        e0_d = cyc + 1;
        send_frame(1, 8'hC3, 1'b1, 7, -1);
        repeat (8) @(negedge clk);
        check("t6_p7_byte",    {24'b0, byte_o[1]}, 32'hC3);
        check("t6_p7_dv_edge", last_dv[1], e0_d + 69);
        e0_d = cyc + 1;
        send_frame(2, 8'hC3, 1'b1, 9, -1);
        repeat (8) @(negedge clk);
        check("t6_p9_byte",    {24'b0, byte_o[2]}, 32'hC3);
        check("t6_p9_dv_edge", last_dv[2], e0_d + 88);
        check("t6_ferr_p7",    fe_cnt[1], 0);
        check("t6_ferr_p9",    fe_cnt[2], 0);
        check("t6_dv_p7",      dv_cnt[1], 1);
        check("t6_dv_p9",      dv_cnt[2], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
